// File: rtl/matmul_pkg.sv
// Shared types and constants for the matrix-multiply memory master.
package matmul_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    MAC  = 3'd3,
    WR_C = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam int          WORD_BYTES = 4;
  localparam logic [16:0] A_BASE_DEF = 17'h00200;
  localparam logic [16:0] B_BASE_DEF = 17'h00300;
  localparam logic [16:0] C_BASE_DEF = 17'h00100;

  // Counter width for an index 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/matmul_addr_gen.sv
// Combinational byte-address generator: picks A[i][k], B[k][j] or C[i][j] by state.
module matmul_addr_gen
  import matmul_pkg::*;
#(
  parameter int                N      = 3,
  parameter int                ADDR_W = 17,
  parameter int                CNT_W  = 2,
  parameter logic [ADDR_W-1:0] A_BASE = A_BASE_DEF,
  parameter logic [ADDR_W-1:0] B_BASE = B_BASE_DEF,
  parameter logic [ADDR_W-1:0] C_BASE = C_BASE_DEF
) (
  input  state_t             state,
  input  logic [CNT_W-1:0]   i,
  input  logic [CNT_W-1:0]   j,
  input  logic [CNT_W-1:0]   k,
  output logic [ADDR_W-1:0]  addr
);

  // Row-major byte offset, truncated to the address width.
  function automatic logic [ADDR_W-1:0] offs(input logic [CNT_W-1:0] r,
                                             input logic [CNT_W-1:0] c);
    int idx;
    idx = int'(r) * N + int'(c);
    return ADDR_W'(idx * WORD_BYTES);
  endfunction

  always_comb begin
    addr = '0;
    case (state)
      RD_A:    addr = A_BASE + offs(i, k);
      RD_B:    addr = B_BASE + offs(k, j);
      WR_C:    addr = C_BASE + offs(i, j);
      default: addr = '0;
    endcase
  end

endmodule

// File: rtl/matmul_mem_master.sv
// Memory-port initiator computing C = A x B one element at a time (read A, read B, MAC; write C).
module matmul_mem_master
  import matmul_pkg::*;
#(
  parameter int                N      = 3,
  parameter int                ADDR_W = 17,
  parameter int                DATA_W = 32,
  parameter logic [ADDR_W-1:0] A_BASE = A_BASE_DEF,
  parameter logic [ADDR_W-1:0] B_BASE = B_BASE_DEF,
  parameter logic [ADDR_W-1:0] C_BASE = C_BASE_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int               CNT_W = cnt_w(N);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(N - 1);

  state_t             state;
  logic [CNT_W-1:0]   i, j, k;
  logic [DATA_W-1:0]  acc, a_reg, b_reg;
  logic [ADDR_W-1:0]  addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      i     <= '0;
      j     <= '0;
      k     <= '0;
      acc   <= '0;
      a_reg <= '0;
      b_reg <= '0;
    end else begin
      case (state)
        IDLE: if (start) state <= RD_A;
        RD_A: begin
          a_reg <= mem_rdata;
          state <= RD_B;
        end
        RD_B: begin
          b_reg <= mem_rdata;
          state <= MAC;
        end
        MAC: begin
          // Product keeps only the low DATA_W bits; acc wraps silently.
          acc <= acc + a_reg * b_reg;
          if (k == LAST) begin
            k     <= '0;
            state <= WR_C;
          end else begin
            k     <= k + 1'b1;
            state <= RD_A;
          end
        end
        WR_C: begin
          acc <= '0;
          if (j == LAST) begin
            j <= '0;
            if (i == LAST) begin
              i     <= '0;
              state <= DONE;
            end else begin
              i     <= i + 1'b1;
              state <= RD_A;
            end
          end else begin
            j     <= j + 1'b1;
            state <= RD_A;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  matmul_addr_gen #(
    .N(N), .ADDR_W(ADDR_W), .CNT_W(CNT_W),
    .A_BASE(A_BASE), .B_BASE(B_BASE), .C_BASE(C_BASE)
  ) u_addr_gen (
    .state(state), .i(i), .j(j), .k(k), .addr(addr)
  );

  // Moore decode straight off the state register; addr_gen already zeroes idle cycles.
  assign mem_read  = (state == RD_A) || (state == RD_B);
  assign mem_write = (state == WR_C);
  assign mem_addr  = addr;
  assign mem_wdata = (state == WR_C) ? acc : '0;
  assign busy      = (state != IDLE) && (state != DONE);
  assign done      = (state == DONE);

endmodule

// File: tb/tb_matmul_mem_master.sv
// Directed bench: table of A/B/expected-C vectors plus reset, ignored-start and back-to-back sequences.
module tb_matmul_mem_master;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        busy, done, mem_read, mem_write;
  logic [16:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  matmul_mem_master dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory model: combinational read, write on clock edge, bulk image load.
  logic [31:0] mem      [0:255];
  logic [31:0] init_img [0:255];
  logic        ld = 1'b0;

  always_comb mem_rdata = mem_read ? mem[mem_addr[9:2]] : 32'h0;

  always @(posedge clk) begin
    if (ld) begin
      for (int x = 0; x < 256; x++) mem[x] <= init_img[x];
    end else if (mem_write) begin
      mem[mem_addr[9:2]] <= mem_wdata;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event log, appended only by the monitor.
  logic [16:0] w_addr[$];
  logic [31:0] w_data[$];
  int          dn_cyc[$];
  int          bs_cyc[$];
  logic        bs_rd[$];
  logic [16:0] bs_addr[$];
  int          ovl = 0;
  logic        busy_q = 1'b0;

  always @(negedge clk) begin
    if (mem_write) begin
      w_addr.push_back(mem_addr);
      w_data.push_back(mem_wdata);
    end
    if (done) dn_cyc.push_back(cyc);
    if (busy && !busy_q) begin
      bs_cyc.push_back(cyc);
      bs_rd.push_back(mem_read);
      bs_addr.push_back(mem_addr);
    end
    if (mem_read && mem_write) ovl = ovl + 1;
    busy_q = busy;
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [8:0][31:0] a;
    logic [8:0][31:0] b;
    logic [8:0][31:0] c;
  } vec_t;

  vec_t vecs[4];

  localparam int unsigned C1[9] = '{30, 36, 42, 66, 81, 96, 102, 126, 150};

  task automatic load(input int v);
    for (int x = 0; x < 256; x++) init_img[x] = 32'h0;
    for (int x = 0; x < 9; x++) begin
      init_img[128 + x] = vecs[v].a[x];
      init_img[192 + x] = vecs[v].b[x];
      init_img[64 + x]  = 32'hDEADBEEF;
    end
    ld = 1'b1;
    @(posedge clk); #1;
    ld = 1'b0;
  endtask

  task automatic check_writes(input int wb, input int v, input string tag);
    for (int r = 0; r < 9; r++) begin
      if (wb + r < w_addr.size()) begin
        chk($sformatf("%s_waddr%0d", tag, r), 64'(w_addr[wb + r]), 64'(17'h100 + 17'(4 * r)));
        chk($sformatf("%s_wdata%0d", tag, r), 64'(w_data[wb + r]), 64'(vecs[v].c[r]));
      end else begin
        chk($sformatf("%s_wmissing%0d", tag, r), 64'(w_addr.size()), 64'(wb + r + 1));
      end
    end
  endtask

  // One full run; optional extra start pulse mid-run that must be ignored.
  task automatic run_vec(input int v, input bit poke, input string tag);
    int t0, wb, db, bb;
    load(v);
    wb = w_addr.size(); db = dn_cyc.size(); bb = bs_cyc.size();
    start = 1'b1;
    t0 = cyc;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      start = poke && (cyc == t0 + 10);
      if (dn_cyc.size() > db) break;
    end
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    if (dn_cyc.size() > db) chk({tag, "_done_cyc"}, 64'(dn_cyc[db] - t0), 64'd91);
    else chk({tag, "_done_timeout"}, 64'(dn_cyc.size()), 64'(db + 1));
    if (bs_cyc.size() > bb) begin
      chk({tag, "_first_cyc"}, 64'(bs_cyc[bb] - t0), 64'd1);
      chk({tag, "_first_rd"}, 64'(bs_rd[bb]), 64'd1);
      chk({tag, "_first_addr"}, 64'(bs_addr[bb]), 64'h200);
    end
    chk({tag, "_runs"}, 64'(bs_cyc.size() - bb), 64'd1);
    chk({tag, "_nwrites"}, 64'(w_addr.size() - wb), 64'd9);
    check_writes(wb, v, tag);
  endtask

  initial begin
    int t0, wb, db, bb;

    for (int x = 0; x < 9; x++) begin
      vecs[0].a[x] = 32'(x + 1);
      vecs[0].b[x] = (x % 4 == 0) ? 32'd1 : 32'd0;
      vecs[0].c[x] = 32'(x + 1);
      vecs[1].a[x] = 32'(x + 1);
      vecs[1].b[x] = 32'(x + 1);
      vecs[1].c[x] = C1[x];
      vecs[2].a[x] = 32'h0;
      vecs[2].b[x] = 32'h0;
      vecs[2].c[x] = 32'h0;
      vecs[3].a[x] = 32'h80000000;
      vecs[3].b[x] = 32'd1;
      vecs[3].c[x] = 32'h80000000;
    end
    vecs[2].a[0] = 32'hFFFFFFFF;
    vecs[2].b[0] = 32'd2;
    vecs[2].c[0] = 32'hFFFFFFFE;

    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_rd", 64'(mem_read), 64'd0);
    chk("rst_wr", 64'(mem_write), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_wdata", 64'(mem_wdata), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    for (int v = 0; v < 4; v++) run_vec(v, 1'b0, $sformatf("vec%0d", v));

    // Reset mid-run
    load(1);
    wb = w_addr.size(); bb = bs_cyc.size();
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 0; n < 100 && cyc != t0 + 40; n++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_rd", 64'(mem_read), 64'd0);
    chk("mid_rst_wr", 64'(mem_write), 64'd0);
    chk("mid_rst_addr", 64'(mem_addr), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("mid_rst_partial_writes", 64'(w_addr.size() - wb), 64'd4);
    chk("mid_rst_no_restart", 64'(bs_cyc.size() - bb), 64'd1);
    run_vec(1, 1'b0, "after_rst");

    // Start pulse while busy is ignored
    run_vec(0, 1'b1, "poke");

    // Start held high: back-to-back runs
    load(1);
    wb = w_addr.size(); db = dn_cyc.size(); bb = bs_cyc.size();
    start = 1'b1;
    t0 = cyc;
    for (int n = 0; n < 250 && bs_cyc.size() < bb + 2; n++) begin
      @(posedge clk); #1;
    end
    start = 1'b0;
    for (int n = 0; n < 200 && dn_cyc.size() < db + 2; n++) begin
      @(posedge clk); #1;
    end
    repeat (3) @(posedge clk);
    #1;
    if (bs_cyc.size() >= bb + 2) begin
      chk("b2b_first_cyc", 64'(bs_cyc[bb] - t0), 64'd1);
      chk("b2b_second_cyc", 64'(bs_cyc[bb + 1] - t0), 64'd93);
    end else begin
      chk("b2b_runs_timeout", 64'(bs_cyc.size() - bb), 64'd2);
    end
    if (dn_cyc.size() >= db + 2) begin
      chk("b2b_done1", 64'(dn_cyc[db] - t0), 64'd91);
      chk("b2b_done2", 64'(dn_cyc[db + 1] - t0), 64'd183);
    end else begin
      chk("b2b_done_timeout", 64'(dn_cyc.size() - db), 64'd2);
    end
    chk("b2b_nwrites", 64'(w_addr.size() - wb), 64'd18);
    check_writes(wb, 1, "b2b_run1");
    check_writes(wb + 9, 1, "b2b_run2");

    chk("no_rd_wr_overlap", 64'(ovl), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
